// File: rtl/fifo_read_pkg.sv
// Shared types and sizing for the FIFO read-side drainer.
package fifo_read_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        ERROR  = 2'd3
    } drain_state_e;

    localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry valid/ready buffer; entry 0 is the head and drives the output.
module fifo_skid_buf
    import fifo_read_pkg::*;
#(
    parameter int FIFO_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [FIFO_WIDTH-1:0] din,
    input  logic                  pop,
    output logic                  valid,
    output logic [FIFO_WIDTH-1:0] dout,
    output logic [1:0]            count
);

    logic [FIFO_WIDTH-1:0] mem0;
    logic [FIFO_WIDTH-1:0] mem1;
    logic [1:0]            cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0 <= '0;
            mem1 <= '0;
            cnt  <= 2'd0;
        end else begin
            assert (!(push && !pop && (cnt == 2'(BUF_DEPTH))));
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) mem0 <= din;
                    else             mem1 <= din;
                    if (cnt != 2'(BUF_DEPTH)) cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    mem0 <= mem1;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    // Head leaves and the new word lands behind whatever remains.
                    if (cnt == 2'd1) begin
                        mem0 <= din;
                    end else begin
                        mem0 <= mem1;
                        mem1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = (cnt != 2'd0);
    assign dout  = mem0;
    assign count = cnt;

endmodule

// File: rtl/fifo_read_drainer.sv
// Read-side master: pulls words from the FIFO and streams them downstream.
//   state  | meaning
//   IDLE   | not fetching, buffer empty
//   ACTIVE | fetching whenever the FIFO has data and local space exists
//   DRAIN  | fetching stopped, buffer and in-flight word still delivered
//   ERROR  | underflow seen, no fetching until enable drops and buffer is empty
module fifo_read_drainer
    import fifo_read_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  err_underflow,
    output logic [CNT_W-1:0]      rd_count
);

    drain_state_e state;
    drain_state_e state_nxt;
    logic         inflight;
    logic         pop;
    logic [1:0]   buf_cnt;
    logic [1:0]   cnt_after_pop;
    logic [2:0]   occ_next;

    fifo_skid_buf #(
        .FIFO_WIDTH(FIFO_WIDTH)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .din   (fifo_data_out),
        .pop   (pop),
        .valid (m_valid),
        .dout  (m_data),
        .count (buf_cnt)
    );

    assign pop           = m_valid && m_ready;
    assign cnt_after_pop = buf_cnt - {1'b0, pop};
    // Occupancy once this cycle's pop leaves and the in-flight word lands.
    assign occ_next      = {1'b0, cnt_after_pop} + {2'b00, inflight};
    assign fifo_rd_en    = (state == ACTIVE) && enable && !fifo_empty
                           && (occ_next < 3'(BUF_DEPTH));
    assign busy          = (buf_cnt != 2'd0) || inflight;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            inflight      <= 1'b0;
            err_underflow <= 1'b0;
            rd_count      <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= fifo_rd_en;
            if (fifo_underflow) err_underflow <= 1'b1;
            if (pop)            rd_count      <= rd_count + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        if (fifo_underflow) begin
            state_nxt = ERROR;
        end else begin
            case (state)
                IDLE:    if (enable) state_nxt = ACTIVE;
                ACTIVE:  if (!enable) state_nxt = DRAIN;
                DRAIN: begin
                    if (enable)     state_nxt = ACTIVE;
                    else if (!busy) state_nxt = IDLE;
                end
                ERROR:   if (!enable && !busy) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_read_drainer.sv
// Bench for fifo_read_drainer: acts as the FIFO and the downstream sink, checks against a word-level model.
module tb_fifo_read_drainer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        fifo_underflow = 1'b0;
    logic [15:0] fifo_data_out = 16'h0;
    logic        m_ready = 1'b0;
    logic        fifo_rd_en;
    logic        m_valid;
    logic [15:0] m_data;
    logic        busy;
    logic        err_underflow;
    logic [15:0] rd_count;

    always #5 clk = ~clk;

    fifo_read_drainer #(.FIFO_WIDTH(16), .CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_data_out  (fifo_data_out),
        .fifo_rd_en     (fifo_rd_en),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_ready        (m_ready),
        .busy           (busy),
        .err_underflow  (err_underflow),
        .rd_count       (rd_count)
    );

    typedef struct {
        logic [15:0] d;
        int          avail;
    } pend_t;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] fq[$];
    pend_t       pend[$];
    int          cyc = 0;
    logic        en_prev = 0, err_prev = 0, err_mode = 0, err_exp = 0;
    logic [15:0] cnt_exp = 0;
    int          delivered = 0, rd_pulses = 0, pushed = 0;
    int          first_hs = -1, last_hs = -1;
    logic [15:0] next_word = 16'h0001;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_words(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd) fq.push_back(16'($urandom));
            else begin
                fq.push_back(next_word);
                next_word = next_word + 16'h1;
            end
            pushed++;
        end
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic clear_counters();
        delivered = 0; rd_pulses = 0; pushed = 0; first_hs = -1; last_hs = -1;
        fq.delete();
        fifo_empty = 1'b1;
    endtask

    // One clock: check outputs against the model, then advance the FIFO and the model.
    task automatic step();
        logic        exp_valid, exp_rd, hs, active, busy_now, rd_s;
        logic [15:0] exp_data;
        pend_t       p;
        #1;
        exp_valid = 1'b0;
        exp_data  = 16'h0;
        if (pend.size() > 0) begin
            if (pend[0].avail <= cyc) begin
                exp_valid = 1'b1;
                exp_data  = pend[0].d;
            end
        end
        busy_now = (pend.size() != 0);
        check("m_valid", m_valid, exp_valid);
        if (exp_valid) check("m_data", m_data, exp_data);
        check("busy", busy, busy_now);
        check("err_underflow", err_underflow, err_exp);
        check("rd_count", rd_count, cnt_exp);
        hs     = exp_valid && m_ready;
        active = en_prev && !err_prev && !err_mode;
        exp_rd = active && enable && (fq.size() != 0) && ((pend.size() - int'(hs)) < 2);
        check("fifo_rd_en", fifo_rd_en, exp_rd);
        rd_s = fifo_rd_en;
        if (hs) begin
            void'(pend.pop_front());
            cnt_exp = cnt_exp + 16'h1;
            delivered++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
        end
        err_prev = err_mode;
        if (fifo_underflow) begin
            err_mode = 1'b1;
            err_exp  = 1'b1;
        end else if (err_mode && !enable && !busy_now) begin
            err_mode = 1'b0;
        end
        en_prev = enable;
        @(posedge clk);
        #1;
        cyc++;
        if (rd_s && fq.size() != 0) begin
            fifo_data_out = fq.pop_front();
            p.d     = fifo_data_out;
            p.avail = cyc + 1;
            pend.push_back(p);
            rd_pulses++;
        end else begin
            fifo_data_out = 16'($urandom);
        end
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0; fifo_underflow = 1'b0;
        #1;
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_underflow, 0);
        check("rst_count", rd_count, 0);
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        pend.delete();
        cnt_exp = 0; err_exp = 0; err_mode = 0; err_prev = 0; en_prev = 0;
        fifo_data_out = 16'($urandom);
    endtask

    initial begin
        int          p;
        logic [15:0] w0;
        #2;
        do_reset();

        // Burst of 8 with m_ready held high.
        clear_counters();
        push_words(8, 0);
        enable = 1'b1; m_ready = 1'b1;
        repeat (16) step();
        check("t1_rd_pulses", rd_pulses, 8);
        check("t1_delivered", delivered, 8);
        check("t1_consecutive", last_hs - first_hs, 7);
        check("t1_rd_count", rd_count, 8);
        check("t1_busy", busy, 0);

        // Backpressure: only two reads until the sink accepts.
        do_reset();
        clear_counters();
        w0 = next_word;
        push_words(8, 0);
        enable = 1'b1; m_ready = 1'b0;
        repeat (10) step();
        check("t2_rd_pulses", rd_pulses, 2);
        check("t2_m_valid", m_valid, 1);
        check("t2_m_data", m_data, w0);
        m_ready = 1'b1;
        repeat (16) step();
        check("t2_delivered", delivered, 8);

        // Disable while a read is in flight.
        do_reset();
        clear_counters();
        push_words(8, 0);
        enable = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 20 && rd_pulses < 3; i++) step();
        check("t3_reached", rd_pulses >= 3, 1);
        enable = 1'b0;
        p = rd_pulses;
        repeat (8) step();
        check("t3_no_more_rd", rd_pulses, p);
        check("t3_delivered", delivered, p);
        check("t3_busy", busy, 0);
        enable = 1'b1;
        repeat (4) step();
        check("t3_resume", rd_pulses > p, 1);

        // Underflow with one word buffered.
        do_reset();
        clear_counters();
        push_words(1, 0);
        enable = 1'b1; m_ready = 1'b0;
        repeat (5) step();
        check("t4_buffered", m_valid, 1);
        push_words(4, 0);
        fifo_underflow = 1'b1;
        step();
        fifo_underflow = 1'b0;
        p = rd_pulses;
        repeat (5) step();
        check("t4_err", err_underflow, 1);
        check("t4_no_rd", rd_pulses, p);
        m_ready = 1'b1;
        repeat (6) step();
        check("t4_delivered", delivered, p);
        check("t4_still_stopped", rd_pulses, p);
        enable = 1'b0;
        repeat (2) step();
        enable = 1'b1;
        repeat (10) step();
        check("t4_resume", rd_pulses > p, 1);
        check("t4_err_sticky", err_underflow, 1);

        // Reset with the buffer full.
        do_reset();
        clear_counters();
        push_words(8, 0);
        enable = 1'b1; m_ready = 1'b0;
        repeat (6) step();
        check("t5_busy_before", busy, 1);
        do_reset();
        delivered = 0;
        m_ready = 1'b1;
        repeat (4) step();
        enable = 1'b1;
        repeat (14) step();
        check("t5_delivered", delivered, 6);

        // Random traffic.
        do_reset();
        clear_counters();
        for (int i = 0; i < 1000; i++) begin
            enable  = ($urandom_range(99) < 95);
            m_ready = ($urandom_range(99) < 30);
            if ($urandom_range(99) < 70) push_words(1, 1);
            step();
        end
        enable = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 2000 && (fq.size() + pend.size()) != 0; i++) step();
        repeat (2) step();
        check("t6_drained", fq.size() + pend.size(), 0);
        check("t6_delivered", delivered, pushed);
        check("t6_rd_count", rd_count, 16'(delivered));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
